// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core (C)
// and the debug/loader (D) ports.
package dmem_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int ARB_WAIT_W = 4;

  typedef enum logic {ARB, DLOCK}     arb_state_e;
  typedef enum logic {PORT_C, PORT_D} arb_port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory signals around the arbiter. The master
// side is the environment (requesters + memory); the slave side is the arbiter.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int W = XLEN
);
  logic         c_req_i, c_we_i, c_gnt_o, c_rvalid_o;
  logic [W-1:0] c_addr_i, c_wdata_i, c_rdata_o;
  logic         d_req_i, d_we_i, d_lock_i, d_gnt_o, d_rvalid_o;
  logic [W-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic         m_req_o, m_we_o;
  logic [W-1:0] m_addr_o, m_wdata_o, m_rdata_i;

  modport master (
    output c_req_i, c_we_i, c_addr_i, c_wdata_i,
    input  c_gnt_o, c_rvalid_o, c_rdata_o,
    output d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  m_req_o, m_we_o, m_addr_o, m_wdata_o,
    output m_rdata_i
  );

  modport slave (
    input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
    output c_gnt_o, c_rvalid_o, c_rdata_o,
    input  d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output m_req_o, m_we_o, m_addr_o, m_wdata_o,
    input  m_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter_wait_ctr.sv
// Saturating wait counter: counts consecutive D losses, clear has priority.
module arb_wait_ctr
  import dmem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_inc,
  input  logic                  i_clr,
  input  logic [ARB_WAIT_W-1:0] i_max,
  output logic                  o_sat
);
  logic [ARB_WAIT_W-1:0] r_cnt;

  assign o_sat = (r_cnt == i_max);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has fixed priority, debug gets a grant after
// MAX_WAIT consecutive losses and may lock the memory for bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int MAX_WAIT = 4
)(
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam logic [0:0]            S_ARB   = ARB;
  localparam logic [0:0]            S_DLOCK = DLOCK;
  localparam logic [ARB_WAIT_W-1:0] W_MAX   = ARB_WAIT_W'(MAX_WAIT);

  logic [0:0]       r_state, w_state_nxt;
  arb_port_e        r_owner;
  logic             r_rd_pend;
  logic             w_sat, w_d_win_arb, w_c_gnt, w_d_gnt, w_m_req, w_m_we;
  logic [XLEN_P-1:0] w_m_addr, w_m_wdata;

  arb_wait_ctr u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .i_inc ((r_state == S_ARB) && bus.d_req_i && !w_d_gnt),
    .i_clr (w_d_gnt || !bus.d_req_i),
    .i_max (W_MAX),
    .o_sat (w_sat)
  );

  assign w_d_win_arb = bus.d_req_i && (!bus.c_req_i || w_sat);
  assign w_d_gnt     = (r_state == S_ARB) ? w_d_win_arb : bus.d_req_i;
  assign w_c_gnt     = (r_state == S_ARB) && bus.c_req_i && !w_d_win_arb;
  assign w_m_req     = w_c_gnt || w_d_gnt;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_m_we    = 1'b0;
    w_m_addr  = '0;
    w_m_wdata = '0;
    if (w_c_gnt) begin
      w_m_we    = bus.c_we_i;
      w_m_addr  = bus.c_addr_i;
      w_m_wdata = bus.c_wdata_i;
    end else if (w_d_gnt) begin
      w_m_we    = bus.d_we_i;
      w_m_addr  = bus.d_addr_i;
      w_m_wdata = bus.d_wdata_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_ARB) begin
      if (w_d_gnt && bus.d_lock_i) w_state_nxt = S_DLOCK;
    end else if (!bus.d_req_i || !bus.d_lock_i) begin
      // Leaving the lock: either the final unlocked access or D went idle.
      w_state_nxt = S_ARB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_ARB;
      r_owner   <= PORT_C;
      r_rd_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_m_req && !w_m_we;
      if (w_m_req && !w_m_we) r_owner <= w_d_gnt ? PORT_D : PORT_C;
    end
  end

  assign bus.c_gnt_o    = w_c_gnt;
  assign bus.d_gnt_o    = w_d_gnt;
  assign bus.m_req_o    = w_m_req;
  assign bus.m_we_o     = w_m_we;
  assign bus.m_addr_o   = w_m_addr;
  assign bus.m_wdata_o  = w_m_wdata;
  assign bus.c_rvalid_o = r_rd_pend && (r_owner == PORT_C);
  assign bus.d_rvalid_o = r_rd_pend && (r_owner == PORT_D);
  assign bus.c_rdata_o  = bus.c_rvalid_o ? bus.m_rdata_i : '0;
  assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.m_rdata_i : '0;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the core load/store port (port C) and the debug/loader port (port D).
- Core has fixed priority. A saturating wait counter guarantees D a grant after MAX_WAIT consecutive losses.
- D may lock the memory for back-to-back burst loads.
- Sits between core_model's datapath/dmem boundary and a synchronous-read data memory with 1-cycle read latency.

Parameters:
- XLEN, 32, data and address width (from riscv_pkg).
- MAX_WAIT, 4, consecutive cycles D may be denied while requesting before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- c_req_i  in  1  core access request
- c_we_i  in  1  core write enable
- c_addr_i  in  XLEN  core byte address
- c_wdata_i  in  XLEN  core write data
- c_gnt_o  out  1  core request accepted this cycle (low = stall core)
- c_rvalid_o  out  1  core read data valid
- c_rdata_o  out  XLEN  core read data
- d_req_i  in  1  debug access request
- d_we_i  in  1  debug write enable
- d_lock_i  in  1  keep grant on D after this access
- d_addr_i  in  XLEN  debug byte address
- d_wdata_i  in  XLEN  debug write data
- d_gnt_o  out  1  debug request accepted this cycle
- d_rvalid_o  out  1  debug read data valid
- d_rdata_o  out  XLEN  debug read data
- m_req_o  out  1  memory access strobe
- m_we_o  out  1  memory write enable
- m_addr_o  out  XLEN  memory address
- m_wdata_o  out  XLEN  memory write data
- m_rdata_i  in  XLEN  memory read data, valid the cycle after a read strobe

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - All gnt/rvalid outputs, m_req_o and m_we_o are 0.
  - rdata outputs and m_addr_o/m_wdata_o are 0.
  - State is ARB, wait counter is 0, owner register is C.
- Grant is combinational in the request cycle: at most one of c_gnt_o/d_gnt_o is high, and gnt implies the matching req.
- m_* signals mux the granted port's signals. m_req_o = c_gnt_o | d_gnt_o. With no grant, m_req_o=0, m_we_o=0, and address/wdata hold 0.
- Requester rule: a request is held with stable fields until gnt; the access completes in the gnt cycle.
- Reads:
  - rvalid of the owner asserts exactly 1 cycle after a granted read; never for writes.
  - rdata = m_rdata_i when the matching rvalid is high, else 0.
  - The owner register captures the granted port on each read grant.
- State ARB:
  - D wins iff d_req_i and (!c_req_i or wait_q == MAX_WAIT). Otherwise C wins if c_req_i.
  - On a D grant with d_lock_i=1, go to DLOCK.
- State DLOCK:
  - Only D may be granted; c_gnt_o=0 even if D is idle.
  - On a D grant with d_lock_i=0, return to ARB.
  - If d_req_i is low for 1 cycle, return to ARB (lock abandoned).
- Wait counter:
  - Width 4 bits.
  - Increments when d_req_i & !d_gnt_o in ARB, saturating at MAX_WAIT.
  - Clears on a D grant or when d_req_i=0.
  - Holds in DLOCK.
- Simultaneous requests with wait_q < MAX_WAIT: C wins, D stalls. After MAX_WAIT losses D wins once, then the counter clears and C regains priority.
- A read granted in the last cycle of DLOCK still returns rvalid to D the next cycle, even if C is granted that same cycle. Pipelined rvalid routing follows the owner register.
- Reset mid-operation: a pending rvalid is squashed (never emitted), lock is dropped, the counter clears.
- Address passes through unmodified; alignment is the requester's responsibility.

Decomposition:
- riscv_pkg additions:
  - typedef enum logic {ARB, DLOCK} arb_state_e
  - typedef enum logic {PORT_C, PORT_D} arb_port_e
  - localparam ARB_WAIT_W = 4
- Optional single sub-module arb_wait_ctr: saturating counter with inc, clr and max inputs, and a sat output. All other logic stays flat.

Test Plan:
- C only, read 0x0100_0010 with memory word 0xDEADBEEF: c_gnt_o=1 same cycle, c_rvalid_o=1 and c_rdata_o=0xDEADBEEF next cycle, d_rvalid_o=0.
- C and D both requesting continuously, MAX_WAIT=4: grant sequence C,C,C,C,D,C,C,C,C,D; wait counter peaks at 4.
- D write 0x0100_0000 with data 0x12345678, d_lock_i=1, then 3 more D writes while c_req_i=1: c_gnt_o stays 0 for all 4 cycles; after the final write with d_lock_i=0, C is granted the next cycle.
- In DLOCK, drop d_req_i for 1 cycle while c_req_i=1: state returns to ARB and C is granted the following cycle.
- D read granted in the same cycle C is granted a write next: d_rvalid_o=1 with D's data, c_rvalid_o=0, and the write appears on m_* with m_we_o=1.
- Assert reset the cycle after a granted read: no rvalid emitted, all outputs 0. After deassertion, D with c_req_i=1 waits the full MAX_WAIT cycles again.
